// File: rtl/multi_timer_if.sv
// Bus port of multi_timer: one request/acknowledge access channel.
//
// Handshake: the master raises valid with we/strb/addr/data_i stable and
// holds them until it sees ready. The slave accepts on the clock edge where
// valid=1 and ready=0, then drives ready=1 for exactly the following cycle.
// Read data on data_o is valid only while ready=1. The master drops valid
// (or presents a new request) after the ready cycle. As a result, each
// access occupies at least two cycles.
interface multi_timer_if #(
    parameter int ADDR_W = 6
) ();
    logic              valid;
    logic              we;
    logic [3:0]        strb;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data_i;
    logic [31:0]       data_o;
    logic              ready;

    modport master (
        output valid, we, strb, addr, data_i,
        input  data_o, ready
    );

    modport slave (
        input  valid, we, strb, addr, data_i,
        output data_o, ready
    );
endinterface

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent CNT_W-bit one-shot/periodic timers behind a
// single word-addressed slave port. Channel events latch into a W1C STATUS
// register. MASK gates STATUS into one registered, level-sensitive irq.
//
// Word map: 0 STATUS, 1 MASK, 2 PRESCALE, 3 reserved.
// Channel n at 4+4n: +0 CTRL{PERIODIC,EN}, +1 MAX, +2 CNT (ro), +3 reserved.
//
// Optional feature macro: MULTI_TIMER_PRESCALE_EN adds a shared 16-bit
// prescaler (PRESCALE at word 2), so one tick occurs every PRESCALE+1 clocks.
// Without the macro, every clock is a tick and word 2 reads as zero.
// Sizing rule: 4+4*NUM_CH must fit in 2**ADDR_W words.
module multi_timer #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int ADDR_W  = 6,
    parameter int MAX_RST = 50
) (
    input  logic         clk,
    input  logic         rst,
    multi_timer_if.slave bus,
    output logic         irq
);

    logic              ready_r;
    logic [31:0]       data_o_r;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] per;
    logic [NUM_CH-1:0] status;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] ev;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] wr_max;
    logic [CNT_W-1:0]  max_r [NUM_CH];
    logic [CNT_W-1:0]  cnt_r [NUM_CH];
    logic              acc;
    logic              wr;
    logic              tick;
    logic [ADDR_W-3:0] blk;
    logic [1:0]        sel;
    logic [31:0]       bmask;
    logic [31:0]       rd_data;

    // Byte-lane merge: keep old bytes where strb is low.
    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    assign acc   = bus.valid & ~ready_r;
    assign wr    = acc & bus.we;
    assign blk   = bus.addr[ADDR_W-1:2];
    assign sel   = bus.addr[1:0];
    assign bmask = {{8{bus.strb[3]}}, {8{bus.strb[2]}},
                    {8{bus.strb[1]}}, {8{bus.strb[0]}}};

    assign bus.ready  = ready_r;
    assign bus.data_o = data_o_r;

`ifdef MULTI_TIMER_PRESCALE_EN
    logic [15:0] prescale;
    logic [15:0] pre_cnt;
    logic        wr_pre;

    assign wr_pre = wr && (blk == '0) && (sel == 2'd2);
    // The >= comparison makes a PRESCALE lowered below pre_cnt wrap on the next clock, rather than after 64k clocks.
    assign tick   = (|en) && (pre_cnt >= prescale);

    // Shared prescaler: runs only while some channel is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= '0;
            pre_cnt  <= '0;
        end else begin
            if (wr_pre) begin
                prescale <= 16'(merge(32'(prescale), bus.data_i, bmask));
            end
            if (!(|en)) begin
                pre_cnt <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 16'd1;
            end
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Per-channel event detection and channel register write strobes.
    always_comb begin
        ev      = '0;
        wr_ctrl = '0;
        wr_max  = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            ev[n]      = en[n] & tick & (cnt_r[n] >= max_r[n]);
            // CTRL lives entirely in byte 0, so lane 0 alone decides the write.
            wr_ctrl[n] = wr && bus.strb[0] && (blk == (ADDR_W-2)'(n + 1)) && (sel == 2'd0);
            wr_max[n]  = wr && (blk == (ADDR_W-2)'(n + 1)) && (sel == 2'd1);
        end
    end

    // Read mux; reserved and unmapped words return zero.
    always_comb begin
        rd_data = '0;
        if (blk == '0) begin
            case (sel)
                2'd0:    rd_data = 32'(status);
                2'd1:    rd_data = 32'(mask);
`ifdef MULTI_TIMER_PRESCALE_EN
                2'd2:    rd_data = 32'(prescale);
`endif
                default: rd_data = '0;
            endcase
        end
        for (int n = 0; n < NUM_CH; n++) begin
            if (blk == (ADDR_W-2)'(n + 1)) begin
                case (sel)
                    2'd0:    rd_data = {30'd0, per[n], en[n]};
                    2'd1:    rd_data = 32'(max_r[n]);
                    2'd2:    rd_data = 32'(cnt_r[n]);
                    default: rd_data = '0;
                endcase
            end
        end
    end

    // Bus acknowledge, read data, STATUS/MASK and the registered irq.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r  <= 1'b0;
            data_o_r <= '0;
            status   <= '0;
            mask     <= '0;
            irq      <= 1'b0;
        end else begin
            ready_r  <= acc;
            data_o_r <= (acc && !bus.we) ? rd_data : '0;
            // A new event on the same edge as a W1C keeps the bit set.
            if (wr && (blk == '0) && (sel == 2'd0)) begin
                status <= (status & ~NUM_CH'(bus.data_i & bmask)) | ev;
            end else begin
                status <= status | ev;
            end
            if (wr && (blk == '0) && (sel == 2'd1)) begin
                mask <= NUM_CH'(merge(32'(mask), bus.data_i, bmask));
            end
            irq <= |(status & mask);
        end
    end

    // Channel counters, enables and compare values.
    always_ff @(posedge clk) begin
        if (rst) begin
            en  <= '0;
            per <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                cnt_r[n] <= '0;
                max_r[n] <= CNT_W'(MAX_RST);
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (!en[n]) begin
                    cnt_r[n] <= '0;
                end else if (tick) begin
                    cnt_r[n] <= ev[n] ? '0 : cnt_r[n] + 1'b1;
                end
                // A CPU write to CTRL overrides the hardware one-shot disable.
                if (wr_ctrl[n]) begin
                    en[n]  <= bus.data_i[0];
                    per[n] <= bus.data_i[1];
                end else if (ev[n] && !per[n]) begin
                    en[n] <= 1'b0;
                end
                if (wr_max[n]) begin
                    max_r[n] <= CNT_W'(merge(32'(max_r[n]), bus.data_i, bmask));
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer (4 channels, 32-bit counters, ADDR_W=6).
// Every comparison goes through check(). Read expectations pass through exp_q.
module tb_multi_timer;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] exp_q[$];

    multi_timer_if #(.ADDR_W(ADDR_W)) bus ();

    multi_timer #(
        .NUM_CH (4),
        .CNT_W  (32),
        .ADDR_W (ADDR_W),
        .MAX_RST(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .irq(irq)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One access: issued just after an edge P, accepted at P+1, and returning just after P+2.
    task automatic bus_xfer(input logic wr, input logic [ADDR_W-1:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.valid  = 1'b1;
        bus.we     = wr;
        bus.addr   = a;
        bus.data_i = d;
        bus.strb   = s;
        @(posedge clk);
        #1;
        while (!bus.ready && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("ready_seen", 32'(bus.ready), 32'd1);
        rd = bus.data_o;
        bus.valid = 1'b0;
        bus.we    = 1'b0;
        @(posedge clk);
        #1;
        check("ready_one_cycle", 32'(bus.ready), 32'd0);
    endtask

    task automatic bus_write_strb(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                                  input logic [3:0] s);
        logic [31:0] unused_rd;
        bus_xfer(1'b1, a, d, s, unused_rd);
    endtask

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bus_write_strb(a, d, 4'hF);
    endtask

    task automatic bus_read(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] e);
        logic [31:0] rd;
        logic [31:0] exp_v;
        exp_q.push_back(e);
        bus_xfer(1'b0, a, 32'd0, 4'h0, rd);
        exp_v = exp_q.pop_front();
        check(tag, rd, exp_v);
    endtask

    task automatic check_irq(input string tag, input logic e);
        check(tag, 32'(irq), 32'(e));
    endtask

    initial begin
        bus.valid  = 1'b0;
        bus.we     = 1'b0;
        bus.strb   = 4'h0;
        bus.addr   = '0;
        bus.data_i = '0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_data_o", bus.data_o, 32'd0);
        check_irq("rst_irq", 1'b0);
        bus_read("rst_max0", 6'd5, 32'd50);
        bus_read("rst_status", 6'd0, 32'd0);
        bus_read("rst_mask", 6'd1, 32'd0);
        bus_read("rst_ctrl0", 6'd4, 32'd0);
        bus_read("rst_cnt0", 6'd6, 32'd0);

        // ch0 periodic, MAX=3: events every 4 clk; CTRL accepted at E
        bus_write(6'd5, 32'd3);
        bus_write(6'd1, 32'd1);
        bus_write(6'd4, 32'd3);            // E, back after E+1
        tick(3);  check_irq("t2_irq_lag", 1'b0);       // E+4: status sets
        tick(1);  check_irq("t2_irq_rise", 1'b1);      // E+5
        bus_read("t2_status", 6'd0, 32'd1);            // accept E+6
        tick(1);                                       // E+8
        bus_write(6'd0, 32'd1);                        // W1C at E+9
        check_irq("t2_irq_fall", 1'b0);                // E+10
        tick(2);  check_irq("t2_irq_low", 1'b0);       // E+12 event
        tick(1);  check_irq("t2_period_rise1", 1'b1);  // E+13
        bus_write(6'd0, 32'd1);                        // W1C at E+14
        check_irq("t2_irq_fall2", 1'b0);               // E+15
        tick(1);  check_irq("t2_irq_low2", 1'b0);      // E+16 event
        tick(1);  check_irq("t2_period_rise2", 1'b1);  // E+17
        bus_write(6'd4, 32'd0);                        // disable at E+18
        bus_write(6'd0, 32'd1);                        // W1C at E+20
        tick(1);  check_irq("t2_irq_off", 1'b0);
        bus_read("t2_cnt_cleared", 6'd6, 32'd0);
        bus_read("t2_status_clear", 6'd0, 32'd0);
        bus_write(6'd1, 32'd0);

        // ch1 one-shot, MAX=5: single event 6 clk after enable
        bus_write(6'd9, 32'd5);
        bus_write(6'd8, 32'd1);                        // E
        bus_read("t3_ctrl_on", 6'd8, 32'd1);           // accept E+2
        bus_read("t3_cnt_mid", 6'd10, 32'd3);          // accept E+4
        tick(2);
        bus_read("t3_ctrl_off", 6'd8, 32'd0);          // accept E+8
        bus_read("t3_cnt_zero", 6'd10, 32'd0);
        bus_read("t3_status", 6'd0, 32'd2);
        check_irq("t3_irq_masked", 1'b0);
        tick(5);
        bus_read("t3_cnt_stays", 6'd10, 32'd0);
        bus_read("t3_status_hold", 6'd0, 32'd2);
        bus_write(6'd0, 32'd2);
        bus_read("t3_status_clr", 6'd0, 32'd0);

        // ch0 and ch2 periodic MAX=9, MASK=0x4; ch0 at E0, ch2 at E2=E0+2
        bus_write(6'd5, 32'd9);
        bus_write(6'd13, 32'd9);
        bus_write(6'd1, 32'd4);
        bus_write(6'd4, 32'd3);                        // E0
        bus_write(6'd12, 32'd3);                       // E2
        tick(7);  check_irq("t4_ch0_no_irq", 1'b0);    // E2+8 ch0 event
        tick(2);  check_irq("t4_irq_lag", 1'b0);       // E2+10 ch2 event
        tick(1);  check_irq("t4_irq_ch2", 1'b1);       // E2+11
        bus_read("t4_status_both", 6'd0, 32'd5);       // accept E2+12
        tick(6);                                       // E2+19
        bus_write(6'd0, 32'd5);                        // W1C at E2+20 = ch2 event
        check_irq("t4_set_wins_irq", 1'b1);
        bus_read("t4_set_wins", 6'd0, 32'd4);
        bus_write(6'd0, 32'd4);                        // W1C at E2+24
        check_irq("t4_irq_clr", 1'b0);
        tick(4);  check_irq("t4_ch0_masked", 1'b0);    // E2+29
        tick(1);  check_irq("t4_irq_lag2", 1'b0);      // E2+30 ch2 event
        tick(1);  check_irq("t4_irq_ch2_again", 1'b1); // E2+31
        bus_write(6'd4, 32'd0);
        bus_write(6'd12, 32'd0);
        bus_write(6'd0, 32'd15);
        bus_write(6'd1, 32'd0);
        bus_read("t4_status_idle", 6'd0, 32'd0);
        check_irq("t4_irq_idle", 1'b0);

        // ch3: lower MAX below CNT (byte-lane write), event on the next tick
        bus_write(6'd16, 32'd3);                       // E
        tick(3);
        bus_read("t5_cnt_4", 6'd18, 32'd4);            // accept E+5
        tick(14);                                      // E+20
        bus_write_strb(6'd17, 32'hFFFF_FF0A, 4'b0001); // MAX=10 at E+21
        bus_read("t5_cnt_wrap", 6'd18, 32'd0);         // event at E+22
        bus_read("t5_max_strb", 6'd17, 32'd10);
        bus_read("t5_status", 6'd0, 32'd8);
        bus_write(6'd16, 32'd0);
        bus_write(6'd0, 32'd15);
        bus_read("t5_unmapped3", 6'd3, 32'd0);
        bus_read("t5_addr_range", 6'd40, 32'd0);
        bus_write(6'd7, 32'hDEAD_BEEF);
        bus_read("t5_reserved7", 6'd7, 32'd0);
        bus_write(6'd1, 32'hFF);
        bus_read("t5_mask_width", 6'd1, 32'hF);
        bus_write(6'd1, 32'd0);
        bus_write(6'd2, 32'd7);
`ifdef MULTI_TIMER_PRESCALE_EN
        bus_read("t5_prescale_rw", 6'd2, 32'd7);

        // Prescaler: PRESCALE=3, MAX=1 periodic; events every 8 clk
        bus_write(6'd2, 32'd3);
        bus_write(6'd5, 32'd1);
        bus_write(6'd1, 32'd1);
        bus_write(6'd4, 32'd3);                        // E
        tick(7);  check_irq("t6_irq_lag", 1'b0);       // E+8 event
        tick(1);  check_irq("t6_irq_rise", 1'b1);
        bus_write(6'd0, 32'd1);                        // W1C at E+10
        check_irq("t6_irq_fall", 1'b0);
        tick(5);  check_irq("t6_irq_low", 1'b0);       // E+16 event
        tick(1);  check_irq("t6_irq_rise2", 1'b1);
        bus_read("t6_prescale", 6'd2, 32'd3);
`else
        bus_read("t5_prescale_off", 6'd2, 32'd0);
`endif

        // Reset mid-operation with an access in flight
        bus_write(6'd17, 32'd77);
        bus_write(6'd1, 32'd8);
        bus_write(6'd16, 32'd3);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = 6'd17;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        check("rst_drop_ready", 32'(bus.ready), 32'd0);
        check("rst_drop_data", bus.data_o, 32'd0);
        bus.valid = 1'b0;
        rst       = 1'b0;
        tick(1);
        check("rst_still_idle", 32'(bus.ready), 32'd0);
        bus_read("rst_max3_back", 6'd17, 32'd50);
        bus_read("rst_ctrl3_back", 6'd16, 32'd0);
        bus_read("rst_mask_back", 6'd1, 32'd0);
        bus_read("rst_cnt3_back", 6'd18, 32'd0);
        check_irq("rst_irq_back", 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
